// File: rtl/uart_axi_bridge_master_pkg.sv
// Shared encodings for the UART-to-AXI4-Lite bridge: AXI response codes, frame bytes, FSM states.
package uart_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] CMD_WRITE   = 8'h57;
  localparam logic [7:0] CMD_READ    = 8'h52;

  localparam logic [7:0] RSP_BASE    = 8'hA0;
  localparam logic [7:0] RSP_BADCMD  = 8'hEE;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE1;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    SEND
  } state_t;

  // Status byte returned to the host for a completed AXI transaction.
  function automatic logic [7:0] rsp_status(input logic [1:0] resp);
    return RSP_BASE | {6'd0, resp};
  endfunction

endpackage

// File: rtl/uart_axi_bridge_master_if.sv
// AXI4-Lite bus between the bridge (master) and the interconnect (slave); all five channels.
interface uart_axi_bridge_master_if #(
  parameter int AXI_ADDR_BW_p = 12
);

  logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr;
  logic                     o_axi_awvalid;
  logic                     i_axi_awready;

  logic [31:0]              o_axi_wdata;
  logic                     o_axi_wvalid;
  logic                     i_axi_wready;

  logic [1:0]               i_axi_bresp;
  logic                     i_axi_bvalid;
  logic                     o_axi_bready;

  logic [AXI_ADDR_BW_p-1:0] o_axi_araddr;
  logic                     o_axi_arvalid;
  logic                     i_axi_arready;

  logic [31:0]              i_axi_rdata;
  logic [1:0]               i_axi_rresp;
  logic                     i_axi_rvalid;
  logic                     o_axi_rready;

  modport master (
    output o_axi_awaddr, o_axi_awvalid, input  i_axi_awready,
    output o_axi_wdata,  o_axi_wvalid,  input  i_axi_wready,
    input  i_axi_bresp,  i_axi_bvalid,  output o_axi_bready,
    output o_axi_araddr, o_axi_arvalid, input  i_axi_arready,
    input  i_axi_rdata,  i_axi_rresp,   i_axi_rvalid, output o_axi_rready
  );

  modport slave (
    input  o_axi_awaddr, o_axi_awvalid, output i_axi_awready,
    input  o_axi_wdata,  o_axi_wvalid,  output i_axi_wready,
    output i_axi_bresp,  i_axi_bvalid,  input  o_axi_bready,
    input  o_axi_araddr, o_axi_arvalid, output i_axi_arready,
    output i_axi_rdata,  i_axi_rresp,   i_axi_rvalid, input o_axi_rready
  );

endinterface

// File: rtl/uart_axi_bridge_master.sv
// UART command frames -> single AXI4-Lite read/write; valid rises the cycle after the last request byte, replies start the cycle after capture.
// Stalls on RX empty / TX full without losing bytes; optional inter-byte timeout under UART_AXI_BRIDGE_TIMEOUT_EN.
module uart_axi_bridge_master
  import uart_axi_pkg::*;
#(
  parameter int AXI_ADDR_BW_p    = 12,
  parameter int TIMEOUT_CYCLES_p = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       i_rx_fifo_data,
  input  logic                             i_rx_fifo_empty,
  output logic                             o_rx_fifo_rd_en,
  input  logic                             i_tx_fifo_full,
  output logic                             o_tx_fifo_wr_en,
  output logic [7:0]                       o_tx_fifo_data,
  uart_axi_bridge_master_if.master         axi,
  output logic                             o_busy
);

  state_t                   state_q, state_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     is_wr_q, is_wr_d;
  logic [AXI_ADDR_BW_p-1:0] addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic [39:0]              tx_sh_q, tx_sh_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     arvalid_q, arvalid_d;

  logic                     rx_pop;
  logic                     tx_push;
  logic                     tmo_hit;
  logic [AXI_ADDR_BW_p-1:0] addr_shift;

  assign rx_pop  = (state_q inside {IDLE, GET_ADDR, GET_DATA}) && !i_rx_fifo_empty && !rst;
  assign tx_push = (state_q == SEND) && !i_tx_fifo_full && !rst;

  assign o_rx_fifo_rd_en = rx_pop;
  assign o_tx_fifo_wr_en = tx_push;
  assign o_tx_fifo_data  = tx_sh_q[39:32];
  assign o_busy          = (state_q != IDLE);

  assign axi.o_axi_awaddr  = addr_q;
  assign axi.o_axi_awvalid = awvalid_q;
  assign axi.o_axi_wdata   = data_q;
  assign axi.o_axi_wvalid  = wvalid_q;
  assign axi.o_axi_bready  = (state_q == WR_RESP);
  assign axi.o_axi_araddr  = addr_q;
  assign axi.o_axi_arvalid = arvalid_q;
  assign axi.o_axi_rready  = (state_q == RD_RESP);

  // Shifting by a full byte keeps only the low AXI_ADDR_BW_p bits of {ADDR_HI, ADDR_LO}.
  assign addr_shift = (addr_q << 8) | AXI_ADDR_BW_p'(i_rx_fifo_data);

`ifdef UART_AXI_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES_p + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             in_frame;

  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign tmo_hit  = in_frame && !rx_pop && (tmo_q == TMO_W'(TIMEOUT_CYCLES_p - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || rx_pop || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_sh_d   = tx_sh_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;

    case (state_q)
      IDLE: begin
        if (rx_pop) begin
          cnt_d = '0;
          if (i_rx_fifo_data == CMD_WRITE || i_rx_fifo_data == CMD_READ) begin
            is_wr_d = (i_rx_fifo_data == CMD_WRITE);
            state_d = GET_ADDR;
          end else begin
            tx_sh_d = {RSP_BADCMD, 32'd0};
            cnt_d   = 3'd1;
            state_d = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (rx_pop) begin
          addr_d = addr_shift;
          if (cnt_q == 3'd1) begin
            cnt_d = '0;
            if (is_wr_q) begin
              state_d = GET_DATA;
            end else begin
              arvalid_d = 1'b1;
              state_d   = RD_REQ;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (tmo_hit) begin
          tx_sh_d = {RSP_TIMEOUT, 32'd0};
          cnt_d   = 3'd1;
          state_d = SEND;
        end
      end

      GET_DATA: begin
        if (rx_pop) begin
          data_d = {data_q[23:0], i_rx_fifo_data};
          if (cnt_q == 3'd3) begin
            cnt_d     = '0;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (tmo_hit) begin
          tx_sh_d = {RSP_TIMEOUT, 32'd0};
          cnt_d   = 3'd1;
          state_d = SEND;
        end
      end

      // AW and W complete independently; leave only once both have handshaken.
      WR_REQ: begin
        if (awvalid_q && axi.i_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.i_axi_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || axi.i_axi_awready) && (!wvalid_q || axi.i_axi_wready)) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (axi.i_axi_bvalid) begin
          tx_sh_d = {rsp_status(axi.i_axi_bresp), 32'd0};
          cnt_d   = 3'd1;
          state_d = SEND;
        end
      end

      RD_REQ: begin
        if (axi.i_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_RESP;
        end
      end

      RD_RESP: begin
        if (axi.i_axi_rvalid) begin
          tx_sh_d = {rsp_status(axi.i_axi_rresp), axi.i_axi_rdata};
          cnt_d   = 3'd5;
          state_d = SEND;
        end
      end

      SEND: begin
        if (tx_push) begin
          tx_sh_d = tx_sh_q << 8;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_sh_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_sh_q   <= tx_sh_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

endmodule

// File: tb/tb_uart_axi_bridge_master.sv
// Directed bench for uart_axi_bridge_master: RX/TX FIFO models plus a small AXI4-Lite register slave.
module tb_uart_axi_bridge_master;
  import uart_axi_pkg::*;

  localparam int AW  = 12;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_rd_en;
  logic       tx_full;
  logic       tx_wr_en;
  logic [7:0] tx_data;
  logic       busy;

  uart_axi_bridge_master_if #(.AXI_ADDR_BW_p(AW)) axi ();

  uart_axi_bridge_master #(
    .AXI_ADDR_BW_p   (AW),
    .TIMEOUT_CYCLES_p(TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_fifo_data (rx_data),
    .i_rx_fifo_empty(rx_empty),
    .o_rx_fifo_rd_en(rx_rd_en),
    .i_tx_fifo_full (tx_full),
    .o_tx_fifo_wr_en(tx_wr_en),
    .o_tx_fifo_data (tx_data),
    .axi            (axi),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bench-side FIFOs and slave state
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] cfg_reg = 32'h0000_0683;
  logic [31:0] scratch = 32'h0;
  int          aw_delay = 0, aw_wait = 0, full_hold = 0;
  int          wr_cnt = 0, aw_hi = 0, w_hi = 0, wr_while_full = 0;
  int          cyc = 0, last_pop_cyc = 0, aw_rise_cyc = 0, ar_rise_cyc = 0;
  int          r_fire_cyc = 0, first_tx_cyc = 0, last_tx_cyc = 0, idle_cyc = 0;
  logic        first_tx_pend = 1'b0;
  logic        aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0, rx_pop = 0;
  logic        aw_got = 0, w_got = 0, prev_aw = 0, prev_ar = 0, prev_busy = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [31:0]   cap_wdata = '0;

  // Observation: values at a negedge are exactly those the next posedge will sample.
  always @(negedge clk) begin
    cyc++;
    aw_fire = axi.o_axi_awvalid && axi.i_axi_awready;
    w_fire  = axi.o_axi_wvalid  && axi.i_axi_wready;
    b_fire  = axi.i_axi_bvalid  && axi.o_axi_bready;
    ar_fire = axi.o_axi_arvalid && axi.i_axi_arready;
    r_fire  = axi.i_axi_rvalid  && axi.o_axi_rready;
    rx_pop  = rx_rd_en;
    if (aw_fire) cap_awaddr = axi.o_axi_awaddr;
    if (w_fire)  cap_wdata  = axi.o_axi_wdata;
    if (ar_fire) cap_araddr = axi.o_axi_araddr;
    if (rx_rd_en) last_pop_cyc = cyc;
    if (axi.o_axi_awvalid) aw_hi++;
    if (axi.o_axi_wvalid)  w_hi++;
    if (axi.o_axi_awvalid && !prev_aw) aw_rise_cyc = cyc;
    if (axi.o_axi_arvalid && !prev_ar) ar_rise_cyc = cyc;
    if (r_fire) r_fire_cyc = cyc;
    if (tx_wr_en) begin
      tx_q.push_back(tx_data);
      last_tx_cyc = cyc;
      if (first_tx_pend) begin
        first_tx_cyc  = cyc;
        first_tx_pend = 1'b0;
      end
      if (tx_full) wr_while_full++;
    end
    if (!busy && prev_busy) idle_cyc = cyc;
    prev_aw   = axi.o_axi_awvalid;
    prev_ar   = axi.o_axi_arvalid;
    prev_busy = busy;
  end

  // Drive: FIFO flags and slave responses change 1 time unit after each posedge.
  initial begin
    logic [7:0] dummy;
    tx_full = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
    axi.i_axi_awready = 0; axi.i_axi_wready = 0; axi.i_axi_bvalid = 0; axi.i_axi_bresp = 0;
    axi.i_axi_arready = 0; axi.i_axi_rvalid = 0; axi.i_axi_rdata = 0; axi.i_axi_rresp = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        axi.i_axi_awready = 0; axi.i_axi_wready = 0; axi.i_axi_bvalid = 0;
        axi.i_axi_arready = 0; axi.i_axi_rvalid = 0;
        aw_got = 0; w_got = 0; aw_wait = 0;
      end else begin
        if (rx_pop && rx_q.size() > 0) dummy = rx_q.pop_front();
        if (aw_fire) aw_got = 1;
        if (w_fire)  w_got  = 1;
        if (b_fire)  axi.i_axi_bvalid = 0;
        if (r_fire)  axi.i_axi_rvalid = 0;
        if (ar_fire) begin
          axi.i_axi_rvalid = 1;
          case (cap_araddr)
            12'h008: begin axi.i_axi_rdata = cfg_reg; axi.i_axi_rresp = RESP_OKAY; end
            12'h00C: begin axi.i_axi_rdata = scratch; axi.i_axi_rresp = RESP_OKAY; end
            default: begin axi.i_axi_rdata = 32'hDEAD_DEAD; axi.i_axi_rresp = RESP_SLVERR; end
          endcase
        end
        if (aw_got && w_got && !axi.i_axi_bvalid) begin
          wr_cnt++;
          axi.i_axi_bvalid = 1;
          axi.i_axi_bresp  = RESP_OKAY;
          case (cap_awaddr)
            12'h008: cfg_reg = cap_wdata;
            12'h00C: scratch = cap_wdata;
            default: axi.i_axi_bresp = RESP_SLVERR;
          endcase
          aw_got = 0; w_got = 0;
        end
        if (!axi.o_axi_awvalid) begin
          aw_wait = 0; axi.i_axi_awready = 0;
        end else if (aw_wait >= aw_delay) begin
          axi.i_axi_awready = 1;
        end else begin
          axi.i_axi_awready = 0; aw_wait++;
        end
        axi.i_axi_wready  = axi.o_axi_wvalid;
        axi.i_axi_arready = axi.o_axi_arvalid;
        tx_full = (full_hold > 0);
        if (full_hold > 0) full_hold--;
      end
      rx_empty = (rx_q.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end
  end

  task automatic frame(input logic [55:0] b, input int n);
    for (int i = 0; i < n; i++) rx_q.push_back(b[8*(n-1-i) +: 8]);
  endtask

  // Wait (bounded) for n response bytes and an idle FSM, then compare the bytes.
  task automatic expect_tx(input string tag, input int n, input logic [39:0] exp);
    logic [39:0] got;
    for (int i = 0; i < 400 && (tx_q.size() < n || busy); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_val({tag, "_n"}, 64'(tx_q.size()), 64'(n));
    got = '0;
    for (int i = 0; i < tx_q.size() && i < 5; i++) got = {got[31:0], tx_q[i]};
    check_val(tag, {24'd0, got}, {24'd0, exp});
    tx_q.delete();
  endtask

  initial begin
    int wr0;
    // Reset behaviour with a byte waiting in RX
    rx_q.push_back(8'h41);
    repeat (3) @(negedge clk);
    check_val("rst_rd_en", rx_rd_en, 0);
    check_val("rst_wr_en", tx_wr_en, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_valids", {axi.o_axi_awvalid, axi.o_axi_wvalid, axi.o_axi_arvalid}, 0);
    check_val("rst_readies", {axi.o_axi_bready, axi.o_axi_rready}, 0);
    check_val("rst_addr_data", {axi.o_axi_awaddr, axi.o_axi_wdata}, 0);
    rx_q.delete();
    @(posedge clk); #2 rst = 1'b0;

    // Read CONFIG reset value, with response timing
    first_tx_pend = 1'b1;
    frame(56'h52_00_08, 3);
    expect_tx("rd_cfg_rst", 5, 40'hA0_00_00_06_83);
    check_val("rd_araddr", cap_araddr, 12'h008);
    check_val("ar_latency", 64'(ar_rise_cyc - last_pop_cyc), 1);
    check_val("tx_first_lat", 64'(first_tx_cyc - r_fire_cyc), 1);
    check_val("tx_last_lat", 64'(last_tx_cyc - r_fire_cyc), 5);
    check_val("idle_lat", 64'(idle_cyc - r_fire_cyc), 6);

    // Write CONFIG then read it back
    wr0 = wr_cnt;
    frame(56'h57_00_08_00_00_00_A3, 7);
    expect_tx("wr_cfg", 1, 40'hA0);
    check_val("wr_awaddr", cap_awaddr, 12'h008);
    check_val("wr_wdata", cap_wdata, 32'h0000_00A3);
    check_val("aw_latency", 64'(aw_rise_cyc - last_pop_cyc), 1);
    check_val("wr_count", 64'(wr_cnt - wr0), 1);
    frame(56'h52_00_08, 3);
    expect_tx("rd_cfg_back", 5, 40'hA0_00_00_00_A3);

    // Unmapped read, bad command, then a read with discarded upper address bits
    frame(56'h52_00_1C, 3);
    expect_tx("rd_unmapped", 5, 40'hA2_DE_AD_DE_AD);
    frame(56'h41, 1);
    expect_tx("bad_cmd", 1, 40'hEE);
    frame(56'h52_F0_08, 3);
    expect_tx("rd_trunc", 5, 40'hA0_00_00_00_A3);
    check_val("trunc_araddr", cap_araddr, 12'h008);
    frame(56'h57_00_1C_00_00_00_01, 7);
    expect_tx("wr_unmapped", 1, 40'hA2);

    // Reset while AW is stalled abandons the write
    wr0 = wr_cnt;
    aw_delay = 20;
    frame(56'h57_00_0C_11_22_33_44, 7);
    for (int i = 0; i < 50 && !axi.o_axi_awvalid; i++) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_val("midrst_valids", {axi.o_axi_awvalid, axi.o_axi_wvalid, busy}, 0);
    check_val("midrst_nowrite", 64'(wr_cnt - wr0), 0);
    aw_delay = 0;
    tx_q.delete();

    // AW delayed 3 cycles, W ready at once
    wr0 = wr_cnt;
    aw_delay = 3;
    aw_hi = 0; w_hi = 0;
    frame(56'h57_00_0C_12_34_56_78, 7);
    expect_tx("wr_bp", 1, 40'hA0);
    check_val("bp_aw_cycles", 64'(aw_hi), 4);
    check_val("bp_w_cycles", 64'(w_hi), 1);
    check_val("bp_wr_count", 64'(wr_cnt - wr0), 1);
    check_val("bp_wdata", cap_wdata, 32'h1234_5678);
    aw_delay = 0;

    // TX full for 10 cycles around the read response
    wr_while_full = 0;
    first_tx_pend = 1'b1;
    frame(56'h52_00_0C, 3);
    for (int i = 0; i < 50 && !axi.o_axi_arvalid; i++) @(negedge clk);
    full_hold = 10;
    expect_tx("rd_txfull", 5, 40'hA0_12_34_56_78);
    check_val("no_push_when_full", 64'(wr_while_full), 0);
    check_val("txfull_stalled", 64'((first_tx_cyc - r_fire_cyc) > 1), 1);

`ifdef UART_AXI_BRIDGE_TIMEOUT_EN
    frame(56'h52_00, 2);
    expect_tx("timeout", 1, 40'hE1);
    frame(56'h52_00_08, 3);
    expect_tx("after_timeout", 5, 40'hA0_00_00_00_A3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
